// File: rtl/disp_layer_regctrl.sv
// Display layer register controller: pending/shadow frame-buffer bases swapped at VSYNC start,
// VSYNC interrupt and sticky FIFO flags. Define DISP_ERRIRQ_EN to add the FIFO error interrupt (EIE).
module disp_layer_regctrl #(
  parameter int NUM_LAYERS = 2,
  parameter int FRMCNT_W   = 16
) (
  input  logic                     ACLK,
  input  logic                     ARST,
  input  logic                     DSP_VSYNC_X,
  input  logic [15:0]              WRADDR,
  input  logic [3:0]               BYTEEN,
  input  logic                     WREN,
  input  logic [31:0]              WDATA,
  input  logic [15:0]              RDADDR,
  input  logic                     RDEN,
  output logic [31:0]              RDATA,
  output logic                     DISPON,
  output logic [NUM_LAYERS-1:0]    LAYER_EN,
  output logic [32*NUM_LAYERS-1:0] DISPADDR,
  output logic                     DSP_IRQ,
  input  logic [NUM_LAYERS-1:0]    BUF_UNDER,
  input  logic [NUM_LAYERS-1:0]    BUF_OVER
);

  localparam logic [9:0] IDX_CTRL = 10'h010;
  localparam logic [9:0] IDX_INT  = 10'h011;
  localparam logic [9:0] IDX_FIFO = 10'h012;
  localparam logic [9:0] IDX_FCNT = 10'h013;

  logic [31:0]           pend_addr [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] pend_layer_en;
  logic [NUM_LAYERS-1:0] under, over, under_nxt, over_nxt, under_clr, over_clr;
  logic                  dispon, vie, vie_nxt, vstat, vstat_nxt, eie, err_irq;
  logic                  vsync_prev, vsync_start;
  logic [FRMCNT_W-1:0]   framecnt;
  logic                  wr_sel, wr_ctrl, wr_int, wr_fifo;
  logic [9:0]            wr_idx, rd_idx;
  logic                  unused_ok;

  assign wr_sel  = WREN && (WRADDR[15:12] == 4'h0);
  assign wr_idx  = WRADDR[11:2];
  assign rd_idx  = RDADDR[11:2];
  assign wr_ctrl = wr_sel && (wr_idx == IDX_CTRL);
  assign wr_int  = wr_sel && (wr_idx == IDX_INT);
  assign wr_fifo = wr_sel && (wr_idx == IDX_FIFO);

  // vsync_prev resets to 1 so a low first sample after reset counts as a start edge
  assign vsync_start = vsync_prev && !DSP_VSYNC_X;
  assign DISPON      = dispon;

  // Set events are ORed in after the W1C mask so a coincident set always wins
  assign vie_nxt   = (wr_int && BYTEEN[0]) ? WDATA[0] : vie;
  assign vstat_nxt = vsync_start || (vstat && !(wr_int && BYTEEN[0] && WDATA[1]));
  assign under_clr = (wr_fifo && BYTEEN[0]) ? WDATA[NUM_LAYERS-1:0] : '0;
  assign over_clr  = (wr_fifo && BYTEEN[1]) ? WDATA[8 +: NUM_LAYERS] : '0;
  assign under_nxt = BUF_UNDER | (under & ~under_clr);
  assign over_nxt  = BUF_OVER | (over & ~over_clr);

`ifdef DISP_ERRIRQ_EN
  logic eie_nxt;
  assign eie_nxt = (wr_int && BYTEEN[0]) ? WDATA[2] : eie;
  assign err_irq = eie_nxt && ((|under_nxt) || (|over_nxt));

  always_ff @(posedge ACLK) begin
    if (ARST) eie <= 1'b0;
    else      eie <= eie_nxt;
  end
`else
  assign eie     = 1'b0;
  assign err_irq = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      for (int n = 0; n < NUM_LAYERS; n++) pend_addr[n] <= '0;
      pend_layer_en <= '0;
      dispon        <= 1'b0;
      vie           <= 1'b0;
      vstat         <= 1'b0;
      under         <= '0;
      over          <= '0;
      framecnt      <= '0;
      vsync_prev    <= 1'b1;
      LAYER_EN      <= '0;
      DISPADDR      <= '0;
      DSP_IRQ       <= 1'b0;
    end else begin
      vsync_prev <= DSP_VSYNC_X;
      vie        <= vie_nxt;
      vstat      <= vstat_nxt;
      under      <= under_nxt;
      over       <= over_nxt;
      DSP_IRQ    <= (vstat_nxt && vie_nxt) || err_irq;
      if (vsync_start) framecnt <= framecnt + FRMCNT_W'(1);
      // Shadows sample the pre-write pending values, so a coincident write waits a frame
      if (!dispon || vsync_start) begin
        for (int n = 0; n < NUM_LAYERS; n++) DISPADDR[32*n +: 32] <= pend_addr[n];
        LAYER_EN <= pend_layer_en;
      end
      if (wr_ctrl) begin
        if (BYTEEN[0]) dispon <= WDATA[0];
        if (BYTEEN[1]) pend_layer_en <= WDATA[8 +: NUM_LAYERS];
      end
      for (int n = 0; n < NUM_LAYERS; n++) begin
        if (wr_sel && (wr_idx == 10'(n))) begin
          for (int b = 0; b < 4; b++)
            if (BYTEEN[b]) pend_addr[n][8*b +: 8] <= WDATA[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    RDATA = '0;
    for (int n = 0; n < NUM_LAYERS; n++)
      if (rd_idx == 10'(n)) RDATA = pend_addr[n];
    case (rd_idx)
      IDX_CTRL: begin
        RDATA[0]              = dispon;
        RDATA[1]              = ~DSP_VSYNC_X;
        RDATA[8 +: NUM_LAYERS] = pend_layer_en;
      end
      IDX_INT:  RDATA[2:0] = {eie, vstat, vie};
      IDX_FIFO: begin
        RDATA[NUM_LAYERS-1:0]  = under;
        RDATA[8 +: NUM_LAYERS] = over;
      end
      IDX_FCNT: RDATA[FRMCNT_W-1:0] = framecnt;
      default: ;
    endcase
  end

  // Reads have no side effects; these address bits are outside the decoded range
  assign unused_ok = ^{RDEN, RDADDR[15:12], RDADDR[1:0], WRADDR[1:0]};

endmodule

// File: tb/tb_disp_layer_regctrl.sv
// Self-checking bench for disp_layer_regctrl: directed scenarios plus randomized traffic
// compared against a register-level behavioural model.
`timescale 1ns/1ps
module tb_disp_layer_regctrl;

  localparam int NL = 2;
  localparam int FW = 16;

  logic            ACLK = 1'b0;
  logic            ARST = 1'b1;
  logic            DSP_VSYNC_X = 1'b1;
  logic [15:0]     WRADDR = '0;
  logic [3:0]      BYTEEN = '0;
  logic            WREN = 1'b0;
  logic [31:0]     WDATA = '0;
  logic [15:0]     RDADDR = '0;
  logic            RDEN = 1'b0;
  logic [31:0]     RDATA;
  logic            DISPON;
  logic [NL-1:0]   LAYER_EN;
  logic [32*NL-1:0] DISPADDR;
  logic            DSP_IRQ;
  logic [NL-1:0]   BUF_UNDER = '0;
  logic [NL-1:0]   BUF_OVER = '0;

  disp_layer_regctrl #(.NUM_LAYERS(NL), .FRMCNT_W(FW)) dut (
    .ACLK(ACLK), .ARST(ARST), .DSP_VSYNC_X(DSP_VSYNC_X),
    .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WDATA(WDATA),
    .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA),
    .DISPON(DISPON), .LAYER_EN(LAYER_EN), .DISPADDR(DISPADDR), .DSP_IRQ(DSP_IRQ),
    .BUF_UNDER(BUF_UNDER), .BUF_OVER(BUF_OVER)
  );

  always #5 ACLK = ~ACLK;

  int tests = 0;
  int failures = 0;
  logic [31:0] d;

  // Behavioural model of the register file
  logic [31:0]     m_pend [NL];
  logic [31:0]     m_shadow [NL];
  logic [NL-1:0]   m_pend_en, m_layer_en, m_under, m_over;
  logic            m_dispon, m_vie, m_vstat, m_eie, m_prev, m_irq;
  longint unsigned m_frame;

  function automatic void model_step();
    logic       vs_start, wr;
    logic [9:0] idx;
    if (ARST) begin
      for (int n = 0; n < NL; n++) begin m_pend[n] = '0; m_shadow[n] = '0; end
      m_pend_en = '0; m_layer_en = '0; m_under = '0; m_over = '0;
      m_dispon = 0; m_vie = 0; m_vstat = 0; m_eie = 0; m_irq = 0; m_prev = 1; m_frame = 0;
    end else begin
      vs_start = m_prev && !DSP_VSYNC_X;
      wr  = WREN && (WRADDR[15:12] == 4'h0);
      idx = WRADDR[11:2];
      if (!m_dispon || vs_start) begin
        for (int n = 0; n < NL; n++) m_shadow[n] = m_pend[n];
        m_layer_en = m_pend_en;
      end
      if (vs_start) m_frame = (m_frame + 1) % (64'd1 << FW);
      if (wr && idx == 10'h011 && BYTEEN[0]) begin
        m_vie = WDATA[0];
        if (WDATA[1]) m_vstat = 0;
`ifdef DISP_ERRIRQ_EN
        m_eie = WDATA[2];
`endif
      end
      if (vs_start) m_vstat = 1;
      if (wr && idx == 10'h012) begin
        if (BYTEEN[0]) m_under = m_under & ~WDATA[NL-1:0];
        if (BYTEEN[1]) m_over = m_over & ~WDATA[8 +: NL];
      end
      m_under = m_under | BUF_UNDER;
      m_over  = m_over | BUF_OVER;
      if (wr && idx == 10'h010) begin
        if (BYTEEN[0]) m_dispon = WDATA[0];
        if (BYTEEN[1]) m_pend_en = WDATA[8 +: NL];
      end
      for (int n = 0; n < NL; n++)
        if (wr && idx == 10'(n))
          for (int b = 0; b < 4; b++)
            if (BYTEEN[b]) m_pend[n][8*b +: 8] = WDATA[8*b +: 8];
      m_irq  = (m_vstat && m_vie) || (m_eie && ((|m_under) || (|m_over)));
      m_prev = DSP_VSYNC_X;
    end
  endfunction

  function automatic logic [32*NL-1:0] model_dispaddr();
    logic [32*NL-1:0] v;
    for (int n = 0; n < NL; n++) v[32*n +: 32] = m_shadow[n];
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] a);
    logic [31:0] v;
    logic [9:0]  idx;
    v = '0;
    idx = a[11:2];
    for (int n = 0; n < NL; n++) if (idx == 10'(n)) v = m_pend[n];
    if (idx == 10'h010) begin v[0] = m_dispon; v[1] = ~DSP_VSYNC_X; v[8 +: NL] = m_pend_en; end
    if (idx == 10'h011) v[2:0] = {m_eie, m_vstat, m_vie};
    if (idx == 10'h012) begin v[NL-1:0] = m_under; v[8 +: NL] = m_over; end
    if (idx == 10'h013) v = 32'(m_frame);
    return v;
  endfunction

  function automatic logic [15:0] rand_addr();
    logic [15:0] a;
    case ($urandom_range(0, 7))
      0: a = 16'h0000;
      1: a = 16'h0004;
      2: a = 16'h0008;
      3: a = 16'h0040;
      4: a = 16'h0044;
      5: a = 16'h0048;
      6: a = 16'h004C;
      default: a = {4'($urandom_range(1, 15)), 12'($urandom)};
    endcase
    a[1:0] = 2'($urandom);
    return a;
  endfunction

  task automatic tick();
    @(posedge ACLK);
    model_step();
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [3:0] be, input logic [31:0] v);
    WRADDR = a; BYTEEN = be; WDATA = v; WREN = 1'b1;
    tick();
    WREN = 1'b0; BYTEEN = '0;
  endtask

  task automatic do_read(input logic [15:0] a, output logic [31:0] v);
    RDADDR = a; RDEN = 1'b1;
    #1;
    v = RDATA;
    RDEN = 1'b0;
  endtask

  task automatic apply_reset();
    ARST = 1'b1; WREN = 1'b0; BUF_UNDER = '0; BUF_OVER = '0; DSP_VSYNC_X = 1'b1;
    tick(); tick();
    ARST = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i <= 16'h13; i++) begin
      do_read(16'(i * 4), d);
      tests++;
      if (d !== 32'h0) begin failures++; $display("[TB] FAIL reset_read idx %0h got %h exp 0", i, d); end
    end
    tests++;
    if (DSP_IRQ !== 1'b0) begin failures++; $display("[TB] FAIL reset_irq got %b exp 0", DSP_IRQ); end
    tests++;
    if (DISPADDR !== '0) begin failures++; $display("[TB] FAIL reset_dispaddr got %h exp 0", DISPADDR); end
    tests++;
    if ({DISPON, LAYER_EN} !== '0) begin failures++; $display("[TB] FAIL reset_en got %b exp 0", {DISPON, LAYER_EN}); end
  endtask

  task automatic test_pend_dispoff();
    do_write(16'h0004, 4'hF, 32'h2000_0000);
    tick();
    tests++;
    if (DISPADDR[63:32] !== 32'h2000_0000) begin failures++; $display("[TB] FAIL off_copy got %h exp 20000000", DISPADDR[63:32]); end
    do_write(16'h0004, 4'b0010, 32'h0000_AB00);
    do_read(16'h0004, d);
    tests++;
    if (d !== 32'h2000_AB00) begin failures++; $display("[TB] FAIL byte_write got %h exp 2000ab00", d); end
    tick();
    tests++;
    if (DISPADDR[63:32] !== 32'h2000_AB00) begin failures++; $display("[TB] FAIL off_copy2 got %h exp 2000ab00", DISPADDR[63:32]); end
  endtask

  task automatic test_vsync_shadow();
    do_write(16'h0040, 4'b0001, 32'h1);
    do_write(16'h0040, 4'b0010, 32'h0000_0300);
    do_write(16'h0000, 4'hF, 32'h1000_0000);
    tick(); tick();
    tests++;
    if (DISPADDR[31:0] !== 32'h0) begin failures++; $display("[TB] FAIL hold_addr got %h exp 0", DISPADDR[31:0]); end
    tests++;
    if (LAYER_EN !== 2'b00) begin failures++; $display("[TB] FAIL hold_en got %b exp 00", LAYER_EN); end
    DSP_VSYNC_X = 1'b0;
    tick();
    tests++;
    if (DISPADDR !== 64'h2000_AB00_1000_0000) begin failures++; $display("[TB] FAIL vs_addr got %h exp 2000ab0010000000", DISPADDR); end
    tests++;
    if (LAYER_EN !== 2'b11) begin failures++; $display("[TB] FAIL vs_en got %b exp 11", LAYER_EN); end
    DSP_VSYNC_X = 1'b1;
    tick();
    WRADDR = 16'h0000; BYTEEN = 4'hF; WDATA = 32'h3000_0000; WREN = 1'b1; DSP_VSYNC_X = 1'b0;
    tick();
    WREN = 1'b0; BYTEEN = '0;
    tests++;
    if (DISPADDR[31:0] !== 32'h1000_0000) begin failures++; $display("[TB] FAIL coincide_hold got %h exp 10000000", DISPADDR[31:0]); end
    DSP_VSYNC_X = 1'b1;
    tick(); tick();
    DSP_VSYNC_X = 1'b0;
    tick();
    tests++;
    if (DISPADDR[31:0] !== 32'h3000_0000) begin failures++; $display("[TB] FAIL deferred got %h exp 30000000", DISPADDR[31:0]); end
    DSP_VSYNC_X = 1'b1;
    tick();
  endtask

  task automatic test_irq();
    apply_reset();
    do_write(16'h0044, 4'b0001, 32'h1);
    tests++;
    if (DSP_IRQ !== 1'b0) begin failures++; $display("[TB] FAIL irq_idle got %b exp 0", DSP_IRQ); end
    DSP_VSYNC_X = 1'b0;
    tick();
    tests++;
    if (DSP_IRQ !== 1'b1) begin failures++; $display("[TB] FAIL irq_set got %b exp 1", DSP_IRQ); end
    do_read(16'h0044, d);
    tests++;
    if (d !== 32'h3) begin failures++; $display("[TB] FAIL vstat got %h exp 3", d); end
    for (int k = 0; k < 2; k++) begin
      DSP_VSYNC_X = 1'b1; tick();
      DSP_VSYNC_X = 1'b0; tick();
    end
    DSP_VSYNC_X = 1'b1; tick();
    do_read(16'h004C, d);
    tests++;
    if (d !== 32'd3) begin failures++; $display("[TB] FAIL framecnt got %0d exp 3", d); end
    do_write(16'h0044, 4'b0001, 32'h2);
    tests++;
    if (DSP_IRQ !== 1'b0) begin failures++; $display("[TB] FAIL irq_clear got %b exp 0", DSP_IRQ); end
    do_read(16'h0044, d);
    tests++;
    if (d !== 32'h0) begin failures++; $display("[TB] FAIL int_clear got %h exp 0", d); end
    do_write(16'h0044, 4'b0001, 32'h1);
    DSP_VSYNC_X = 1'b0; tick();
    DSP_VSYNC_X = 1'b1; tick();
    WRADDR = 16'h0044; BYTEEN = 4'b0001; WDATA = 32'h3; WREN = 1'b1; DSP_VSYNC_X = 1'b0;
    tick();
    WREN = 1'b0; BYTEEN = '0;
    do_read(16'h0044, d);
    tests++;
    if (d !== 32'h3) begin failures++; $display("[TB] FAIL set_wins got %h exp 3", d); end
    tests++;
    if (DSP_IRQ !== 1'b1) begin failures++; $display("[TB] FAIL set_wins_irq got %b exp 1", DSP_IRQ); end
    DSP_VSYNC_X = 1'b1; tick();
  endtask

  task automatic test_fifo();
    apply_reset();
    BUF_UNDER = 2'b10; BUF_OVER = 2'b01;
    tick();
    BUF_UNDER = '0; BUF_OVER = '0;
    tick();
    do_read(16'h0048, d);
    tests++;
    if (d !== 32'h0000_0102) begin failures++; $display("[TB] FAIL fifo_sticky got %h exp 102", d); end
    tests++;
    if (DSP_IRQ !== 1'b0) begin failures++; $display("[TB] FAIL fifo_noirq got %b exp 0", DSP_IRQ); end
    do_write(16'h0048, 4'b0001, 32'h2);
    do_read(16'h0048, d);
    tests++;
    if (d !== 32'h0000_0100) begin failures++; $display("[TB] FAIL fifo_w1c got %h exp 100", d); end
    WRADDR = 16'h0048; BYTEEN = 4'b0011; WDATA = 32'h0000_0101; WREN = 1'b1; BUF_UNDER = 2'b01;
    tick();
    WREN = 1'b0; BYTEEN = '0; BUF_UNDER = '0;
    do_read(16'h0048, d);
    tests++;
    if (d !== 32'h0000_0001) begin failures++; $display("[TB] FAIL fifo_set_wins got %h exp 1", d); end
    do_write(16'h0044, 4'b0001, 32'h4);
`ifdef DISP_ERRIRQ_EN
    tests++;
    if (DSP_IRQ !== 1'b1) begin failures++; $display("[TB] FAIL err_irq got %b exp 1", DSP_IRQ); end
    do_write(16'h0048, 4'b0011, 32'h0000_0303);
    tests++;
    if (DSP_IRQ !== 1'b0) begin failures++; $display("[TB] FAIL err_irq_clr got %b exp 0", DSP_IRQ); end
`else
    do_read(16'h0044, d);
    tests++;
    if (d !== 32'h0) begin failures++; $display("[TB] FAIL eie_ro got %h exp 0", d); end
    tests++;
    if (DSP_IRQ !== 1'b0) begin failures++; $display("[TB] FAIL err_irq_off got %b exp 0", DSP_IRQ); end
`endif
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    do_write(16'h0000, 4'hF, 32'hDEAD_BEEF);
    do_write(16'h0040, 4'b0011, 32'h0000_0101);
    do_write(16'h0044, 4'b0001, 32'h1);
    BUF_UNDER = 2'b01; tick(); BUF_UNDER = '0;
    DSP_VSYNC_X = 1'b0; tick();
    DSP_VSYNC_X = 1'b1; tick();
    tests++;
    if (DISPADDR[31:0] !== 32'hDEAD_BEEF || DSP_IRQ !== 1'b1) begin
      failures++; $display("[TB] FAIL pre_reset got %h/%b exp deadbeef/1", DISPADDR[31:0], DSP_IRQ);
    end
    ARST = 1'b1; DSP_VSYNC_X = 1'b0;
    tick();
    tests++;
    if ({DISPADDR, LAYER_EN, DISPON, DSP_IRQ} !== '0) begin
      failures++; $display("[TB] FAIL mid_reset_out got %h %b %b %b exp 0", DISPADDR, LAYER_EN, DISPON, DSP_IRQ);
    end
    do_read(16'h0040, d);
    tests++;
    if (d !== 32'h2) begin failures++; $display("[TB] FAIL mid_reset_ctrl got %h exp 2", d); end
    do_read(16'h0048, d);
    tests++;
    if (d !== 32'h0) begin failures++; $display("[TB] FAIL mid_reset_fifo got %h exp 0", d); end
    ARST = 1'b0;
    tick();
    do_read(16'h004C, d);
    tests++;
    if (d !== 32'd1) begin failures++; $display("[TB] FAIL first_edge got %0d exp 1", d); end
    DSP_VSYNC_X = 1'b1; tick();
  endtask

  task automatic test_random();
    logic [15:0] ra;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      WREN   = ($urandom_range(0, 99) < 40);
      WRADDR = rand_addr();
      BYTEEN = 4'($urandom);
      WDATA  = $urandom;
      if ($urandom_range(0, 5) == 0) DSP_VSYNC_X = ~DSP_VSYNC_X;
      BUF_UNDER = ($urandom_range(0, 9) == 0) ? NL'($urandom) : '0;
      BUF_OVER  = ($urandom_range(0, 9) == 0) ? NL'($urandom) : '0;
      tick();
      tests++;
      if (DISPADDR !== model_dispaddr()) begin failures++; $display("[TB] FAIL rand_dispaddr got %h exp %h", DISPADDR, model_dispaddr()); end
      tests++;
      if (LAYER_EN !== m_layer_en) begin failures++; $display("[TB] FAIL rand_layer_en got %b exp %b", LAYER_EN, m_layer_en); end
      tests++;
      if (DISPON !== m_dispon) begin failures++; $display("[TB] FAIL rand_dispon got %b exp %b", DISPON, m_dispon); end
      tests++;
      if (DSP_IRQ !== m_irq) begin failures++; $display("[TB] FAIL rand_irq got %b exp %b", DSP_IRQ, m_irq); end
      ra = rand_addr();
      do_read(ra, d);
      tests++;
      if (d !== model_read(ra)) begin failures++; $display("[TB] FAIL rand_read %h got %h exp %h", ra, d, model_read(ra)); end
    end
    WREN = 1'b0; BUF_UNDER = '0; BUF_OVER = '0;
  endtask

  initial begin
    test_reset();
    test_pend_dispoff();
    test_vsync_shadow();
    test_irq();
    test_fifo();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout got running exp finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/disp_layer_regctrl.md
Name: disp_layer_regctrl

Overview:
Parametrised register controller for the display pipeline. Holds one frame-buffer base address per layer and applies address changes only at the start of VSYNC, so no frame shows a torn base address. Also provides display/layer enables, a VSYNC interrupt with enable and write-1-to-clear, and per-layer sticky FIFO under/overflow flags. Sits between the register bus bridge and the per-layer display DMA/FIFO blocks.

Parameters:
NUM_LAYERS, 2, number of layers; legal range 1..4
FRMCNT_W, 16, width of frame counter, 1..32

Ports:
ACLK  in  1  clock
ARST  in  1  synchronous active-high reset
DSP_VSYNC_X  in  1  VSYNC, active low, synchronous to ACLK
WRADDR  in  16  write byte address
BYTEEN  in  4  write byte enables
WREN  in  1  write strobe, one cycle per write
WDATA  in  32  write data
RDADDR  in  16  read byte address
RDEN  in  1  read strobe; no side effects
RDATA  out  32  read data, combinational from RDADDR
DISPON  out  1  display enable
LAYER_EN  out  NUM_LAYERS  per-layer enable (shadowed)
DISPADDR  out  32*NUM_LAYERS  active base address; layer n at bits [32n+31:32n] (shadowed)
DSP_IRQ  out  1  interrupt, level, active high
BUF_UNDER  in  NUM_LAYERS  per-layer underflow pulse
BUF_OVER  in  NUM_LAYERS  per-layer overflow pulse

Behaviour:
- One clock (ACLK); reset is synchronous and active-high (ARST). All registers clear on ARST. Outputs after reset: DISPON=0, LAYER_EN=0, DISPADDR=0, DSP_IRQ=0.
- Select: a write hits this block when WREN=1 and WRADDR[15:12]=0. The word index is WRADDR[11:2]. Reads decode RDADDR[11:2] only. Unmapped indices read 0 and ignore writes.
- Register map, by word index:
  - 0x000+n: PEND_ADDR[n] for n<NUM_LAYERS. 32-bit R/W with per-byte BYTEEN. Reads return the pending value.
  - 0x010 DISPCTRL:
    - bit0 DISPON, R/W, immediate; write takes effect when BYTEEN[0]=1.
    - bit1 VBLANK, RO, equals ~DSP_VSYNC_X.
    - bits[8+NUM_LAYERS-1:8] PEND_LAYER_EN, R/W; write takes effect when BYTEEN[1]=1.
  - 0x011 DISPINT:
    - bit0 VIE, R/W.
    - bit1 VSTAT, RO set, W1C.
    - bit2 EIE (see Optional Feature).
    - Writes take effect when BYTEEN[0]=1.
  - 0x012 DISPFIFO:
    - bits[NUM_LAYERS-1:0] UNDER sticky, W1C with BYTEEN[0].
    - bits[8+NUM_LAYERS-1:8] OVER sticky, W1C with BYTEEN[1].
  - 0x013 FRAMECNT: RO, zero-extended to 32 bits.
- VSYNC start: the cycle where the previous sample of DSP_VSYNC_X is 1 and the current is 0. The first sample after reset is treated as 1.
- On VSYNC start:
  - DISPADDR[n] <= PEND_ADDR[n] and LAYER_EN <= PEND_LAYER_EN. Outputs are visible the cycle after the edge.
  - VSTAT <= 1.
  - FRAMECNT increments, wrapping modulo 2^FRMCNT_W.
- While DISPON=0, the shadow registers copy the pending registers every cycle (1-cycle latency), so setup before enable needs no VSYNC.
- Write to PEND_ADDR or PEND_LAYER_EN in the same cycle as VSYNC start: the shadow takes the pre-write value, and the new value applies at the next VSYNC.
- A W1C clear in the same cycle as a set event (VSYNC start or BUF_* pulse): set wins and the bit stays 1.
- DSP_IRQ is registered: DSP_IRQ <= (VSTAT & VIE) computed from next-state values, so it asserts the cycle after the status bit sets. It deasserts the cycle after a clear or after VIE is written to 0.
- A sticky FIFO flag sets on any cycle its BUF_* input is 1.

Optional Feature:
DISP_ERRIRQ_EN:
- Defined: DISPINT bit2 EIE is R/W, and DSP_IRQ <= (VSTAT & VIE) | (EIE & (|UNDER | |OVER)).
- Undefined: EIE reads 0 and ignores writes; FIFO flags never affect DSP_IRQ.

Test Plan:
- Reset, then read indices 0x000..0x013 -> all 0, DSP_IRQ=0, DISPADDR=0.
- DISPON=0, write PEND_ADDR[1]=0x2000_0000 -> DISPADDR[63:32]=0x2000_0000 on the next cycle; a byte write BYTEEN=4'b0010 WDATA=0x0000_AB00 -> PEND_ADDR[1]=0x2000_AB00.
- DISPON=1, write PEND_ADDR[0]=0x1000_0000 -> DISPADDR[31:0] unchanged until VSYNC falls, then updates 1 cycle after the edge; a write coinciding with the edge defers to the following VSYNC.
- VIE=1, three VSYNC falls -> VSTAT=1, DSP_IRQ=1 one cycle after the first edge, FRAMECNT=3. Write DISPINT=0x2 -> DSP_IRQ=0 next cycle; a clear coinciding with a VSYNC edge leaves VSTAT=1.
- Pulse BUF_UNDER[1] and BUF_OVER[0] -> DISPFIFO reads 0x0000_0102. Write 0x0000_0002 -> reads 0x0000_0100. With DISP_ERRIRQ_EN and EIE=1, DSP_IRQ follows the flags.
- ARST asserted mid-frame with DISPON=1 and flags set -> all registers 0 the next cycle. The first VSYNC low sample after reset counts as a start edge; FRAMECNT=1.
